// File: rtl/prpg_seq_ctrl.sv
// prpg_seq_ctrl
// Program sequencer for the 8-bit configurable-tap LFSR PRPG and its pattern
// memory. Each cycle in EXEC it fetches a 14-bit instruction from a
// combinational ROM and decodes it: opcode = instr[13:8], immediate = instr[7:0].
// It then drives registered one-cycle strobes toward the datapath and memory.
// A host start/busy/done handshake wraps program execution, and a sticky error
// flag reports bad opcodes and out-of-range memory accesses.
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for i_start; all strobes low
//   S_EXEC  | decode i_instr at o_pc each cycle
//   S_RUN_N | run_n burst: o_run_en held high while r_cnt counts down
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_start    start program at pc=0 (IDLE only)
//   i_abort    synchronous cancel back to IDLE
//   o_pc       instruction address to ROM
//   i_instr    ROM data for o_pc, same cycle
//   o_cfg_we   load tap register from o_tap
//   o_tap      tap value
//   o_seed_we  load LFSR state from o_seed
//   o_seed     seed value
//   o_run_en   advance LFSR one step
//   o_mem_we   write pattern memory at o_r_addr
//   o_mem_sel  write source: 0=LFSR state, 1=Hamming distance
//   o_ld_en    load LFSR state from memory at o_r_addr
//   o_r_addr   memory address register
//   o_busy     program executing
//   o_done     one-cycle pulse at program end (halt or error)
//   o_err      sticky error, cleared by the next accepted start
module prpg_seq_ctrl #(
    parameter int PC_W      = 6,
    parameter int MEM_DEPTH = 226
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    output logic [PC_W-1:0] o_pc,
    input  logic [13:0]     i_instr,
    output logic            o_cfg_we,
    output logic [6:0]      o_tap,
    output logic            o_seed_we,
    output logic [7:0]      o_seed,
    output logic            o_run_en,
    output logic            o_mem_we,
    output logic            o_mem_sel,
    output logic            o_ld_en,
    output logic [7:0]      o_r_addr,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_RUN_N = 2'd2
    } state_t;

    localparam logic [5:0] OP_HALT      = 6'd0;
    localparam logic [5:0] OP_CONFIG_L  = 6'd1;
    localparam logic [5:0] OP_INIT_L    = 6'd2;
    localparam logic [5:0] OP_RUN_L     = 6'd3;
    localparam logic [5:0] OP_INIT_ADDR = 6'd4;
    localparam logic [5:0] OP_ST_M_L    = 6'd5;
    localparam logic [5:0] OP_ADD_ADDR  = 6'd6;
    localparam logic [5:0] OP_LD_M_L    = 6'd7;
    localparam logic [5:0] OP_ST_M_HD   = 6'd8;
    localparam logic [5:0] OP_RUN_N     = 6'd9;

    // One bit wider than r_addr so a depth of 256 still compares correctly.
    localparam logic [8:0] ADDR_LIM = 9'(MEM_DEPTH);

    state_t          r_state, w_nx_state;
    logic [PC_W-1:0] r_pc, w_nx_pc;
    logic [7:0]      r_addr, w_nx_addr;
    logic [6:0]      r_tap, w_nx_tap;
    logic [7:0]      r_seed, w_nx_seed;
    logic [7:0]      r_cnt, w_nx_cnt;
    logic            r_cfg_we, w_nx_cfg_we;
    logic            r_seed_we, w_nx_seed_we;
    logic            r_run_en, w_nx_run_en;
    logic            r_mem_we, w_nx_mem_we;
    logic            r_mem_sel, w_nx_mem_sel;
    logic            r_ld_en, w_nx_ld_en;
    logic            r_busy, w_nx_busy;
    logic            r_done, w_nx_done;
    logic            r_err, w_nx_err;

    logic [5:0]      w_opcode;
    logic [7:0]      w_imm;
    logic            w_addr_bad;
    logic            w_fault;

    assign w_opcode   = i_instr[13:8];
    assign w_imm      = i_instr[7:0];
    assign w_addr_bad = ({1'b0, r_addr} >= ADDR_LIM);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_addr    <= '0;
            r_tap     <= '0;
            r_seed    <= '0;
            r_cnt     <= '0;
            r_cfg_we  <= 1'b0;
            r_seed_we <= 1'b0;
            r_run_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_sel <= 1'b0;
            r_ld_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nx_state;
            r_pc      <= w_nx_pc;
            r_addr    <= w_nx_addr;
            r_tap     <= w_nx_tap;
            r_seed    <= w_nx_seed;
            r_cnt     <= w_nx_cnt;
            r_cfg_we  <= w_nx_cfg_we;
            r_seed_we <= w_nx_seed_we;
            r_run_en  <= w_nx_run_en;
            r_mem_we  <= w_nx_mem_we;
            r_mem_sel <= w_nx_mem_sel;
            r_ld_en   <= w_nx_ld_en;
            r_busy    <= w_nx_busy;
            r_done    <= w_nx_done;
            r_err     <= w_nx_err;
        end
    end

    always_comb begin
        // Strobes and done are pulses: default low every cycle.
        w_nx_state   = r_state;
        w_nx_pc      = r_pc;
        w_nx_addr    = r_addr;
        w_nx_tap     = r_tap;
        w_nx_seed    = r_seed;
        w_nx_cnt     = r_cnt;
        w_nx_cfg_we  = 1'b0;
        w_nx_seed_we = 1'b0;
        w_nx_run_en  = 1'b0;
        w_nx_mem_we  = 1'b0;
        w_nx_mem_sel = 1'b0;
        w_nx_ld_en   = 1'b0;
        w_nx_busy    = r_busy;
        w_nx_done    = 1'b0;
        w_nx_err     = r_err;
        w_fault      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nx_state = S_EXEC;
                    w_nx_pc    = '0;
                    w_nx_busy  = 1'b1;
                    w_nx_err   = 1'b0;
                end
            end

            S_EXEC: begin
                if (i_abort) begin
                    w_nx_state = S_IDLE;
                    w_nx_busy  = 1'b0;
                end else begin
                    w_nx_pc = r_pc + PC_W'(1);
                    case (w_opcode)
                        OP_HALT: begin
                            w_nx_state = S_IDLE;
                            w_nx_pc    = r_pc;
                            w_nx_busy  = 1'b0;
                            w_nx_done  = 1'b1;
                        end
                        OP_CONFIG_L: begin
                            w_nx_cfg_we = 1'b1;
                            w_nx_tap    = w_imm[6:0];
                        end
                        OP_INIT_L: begin
                            w_nx_seed_we = 1'b1;
                            w_nx_seed    = w_imm;
                        end
                        OP_RUN_L:     w_nx_run_en = 1'b1;
                        OP_INIT_ADDR: w_nx_addr   = w_imm;
                        OP_ADD_ADDR:  w_nx_addr   = r_addr + w_imm;
                        OP_ST_M_L: begin
                            if (w_addr_bad) w_fault     = 1'b1;
                            else            w_nx_mem_we = 1'b1;
                        end
                        OP_ST_M_HD: begin
                            if (w_addr_bad) begin
                                w_fault = 1'b1;
                            end else begin
                                w_nx_mem_we  = 1'b1;
                                w_nx_mem_sel = 1'b1;
                            end
                        end
                        OP_LD_M_L: begin
                            if (w_addr_bad) w_fault    = 1'b1;
                            else            w_nx_ld_en = 1'b1;
                        end
                        OP_RUN_N: begin
                            // The decode cycle supplies the first of imm pulses.
                            if (w_imm != 8'd0) begin
                                w_nx_run_en = 1'b1;
                                w_nx_cnt    = w_imm - 8'd1;
                                w_nx_state  = S_RUN_N;
                            end
                        end
                        default: w_fault = 1'b1;
                    endcase

                    if (w_fault) begin
                        w_nx_state = S_IDLE;
                        w_nx_pc    = r_pc;
                        w_nx_busy  = 1'b0;
                        w_nx_done  = 1'b1;
                        w_nx_err   = 1'b1;
                    end
                end
            end

            S_RUN_N: begin
                if (i_abort) begin
                    w_nx_state = S_IDLE;
                    w_nx_busy  = 1'b0;
                end else if (r_cnt != 8'd0) begin
                    w_nx_cnt    = r_cnt - 8'd1;
                    w_nx_run_en = 1'b1;
                end else begin
                    w_nx_state = S_EXEC;
                end
            end

            default: begin
                w_nx_state = S_IDLE;
                w_nx_busy  = 1'b0;
            end
        endcase
    end

    assign o_pc      = r_pc;
    assign o_cfg_we  = r_cfg_we;
    assign o_tap     = r_tap;
    assign o_seed_we = r_seed_we;
    assign o_seed    = r_seed;
    assign o_run_en  = r_run_en;
    assign o_mem_we  = r_mem_we;
    assign o_mem_sel = r_mem_sel;
    assign o_ld_en   = r_ld_en;
    assign o_r_addr  = r_addr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule
